// File: rtl/pattern_pkg.sv
// Shared constants, state type and the elaboration-time transition table
// builder for pattern_detector.
package pattern_pkg;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
    S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7
  } state_t;

  // Entry {k, b} (4 bits at (2*k+b)*4) holds the longest suffix of
  // prefix(k)+b that is also a pattern prefix, capped at pat_w-1 so the
  // full-match entry doubles as the overlapping restart state.
  function automatic logic [63:0] build_next_table(input int pat_w, input logic [7:0] pattern);
    logic [63:0] tbl;
    int          lim;
    int          best;
    int          pos;
    logic        seq_bit;
    logic        ok;
    tbl = '0;
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        if (k < pat_w) begin
          lim = (k + 1 < pat_w) ? k + 1 : pat_w - 1;
          for (int j = 1; j <= lim; j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
              pos     = k + 1 - j + t;
              seq_bit = (pos == k) ? b[0] : pattern[pat_w-1-pos];
              if (seq_bit != pattern[pat_w-1-t]) ok = 1'b0;
            end
            if (ok) best = j;
          end
        end
        tbl[(2*k+b)*4 +: 4] = best[3:0];
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pattern_detector.sv
// Mealy serial pattern detector (KMP transitions) with optional saturating
// match counter enabled by macro PATTERN_DETECTOR_CNT_EN.
module pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [3:0]       prefix_len
);
  import pattern_pkg::*;

  localparam logic [63:0] NEXT_TBL   = build_next_table(PAT_W, 8'(PATTERN));
  localparam state_t      LAST       = state_t'(PAT_W - 1);
  localparam logic [3:0]  NUM_STATES = 4'(PAT_W);

  state_t     state;
  state_t     next_state;
  logic [5:0] tbl_idx;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S0;
    else
      state <= next_state;
  end

  // Encodings at or above PAT_W are unreachable; they fall back to S0.
  always_comb begin
    next_state = state;
    y          = NOTFOUND;
    tbl_idx    = {state[2:0], x, 2'b00};
    if (!reset && en) begin
      if (state >= NUM_STATES) begin
        next_state = S0;
      end else if ((state == LAST) && (x == PATTERN[0])) begin
        y          = FOUND;
        next_state = (OVERLAP != 0) ? state_t'(NEXT_TBL[tbl_idx +: 4]) : S0;
      end else begin
        next_state = state_t'(NEXT_TBL[tbl_idx +: 4]);
      end
    end
  end

  assign prefix_len = state;

`ifdef PATTERN_DETECTOR_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (y),
    .count (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector: two instances (non-overlapping
// with a 2-bit counter, overlapping with an 8-bit counter) share stimulus.
module tb_pattern_detector;

`ifdef PATTERN_DETECTOR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam int PAT = 11;  // 4'b1011

  logic       clk;
  logic       reset;
  logic       en;
  logic       x;
  logic       y0, y1;
  logic [3:0] p0, p1;
  logic [1:0] c0;
  logic [7:0] c1;

  int errors = 0;
  int checks = 0;

  pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) dut0 (
    .clk(clk), .reset(reset), .en(en), .x(x),
    .y(y0), .match_cnt(c0), .prefix_len(p0)
  );

  pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .x(x),
    .y(y1), .match_cnt(c1), .prefix_len(p1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: history of accepted bits since reset (or since the last match
  // when non-overlapping), matched against the pattern by plain arithmetic.
  logic [31:0] hist [2];
  int          hlen [2];
  int          cnt  [2];
  bit          model_valid = 1'b0;

  function automatic int cnt_max(input int i);
    return (i == 0) ? 3 : 255;
  endfunction

  function automatic bit match_now(input int i);
    logic [31:0] h;
    h = {hist[i][30:0], x};
    return (hlen[i] + 1 >= 4) && (int'(h[3:0]) == PAT);
  endfunction

  function automatic int model_prefix(input int i);
    for (int k = 3; k > 0; k--) begin
      if ((k <= hlen[i]) && (int'(hist[i] & ((32'd1 << k) - 1)) == (PAT >> (4 - k))))
        return k;
    end
    return 0;
  endfunction

  function automatic int exp_y(input int i);
    return (!reset && en && match_now(i)) ? 1 : 0;
  endfunction

  function automatic int exp_cnt(input int i);
    return CNT_ON ? cnt[i] : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        hist[i] <= '0;
        hlen[i] <= 0;
        cnt[i]  <= 0;
      end else if (en) begin
        hist[i] <= {hist[i][30:0], x};
        hlen[i] <= (match_now(i) && (i == 0)) ? 0 : ((hlen[i] < 8) ? hlen[i] + 1 : 8);
        cnt[i]  <= (match_now(i) && (cnt[i] < cnt_max(i))) ? cnt[i] + 1 : cnt[i];
      end
    end
    if (reset) model_valid <= 1'b1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_y0", int'(y0), exp_y(0));
      checkOutput("model_y1", int'(y1), exp_y(1));
      checkOutput("model_prefix0", int'(p0), model_prefix(0));
      checkOutput("model_prefix1", int'(p1), model_prefix(1));
      checkOutput("model_cnt0", int'(c0), exp_cnt(0));
      checkOutput("model_cnt1", int'(c1), exp_cnt(1));
    end
  end

  // Values sampled by the most recent applyStimulus call.
  int sy0, sy1, sp0, sp1, sc0, sc1;

  // Called at posedge+1; samples y mid-cycle, the registered outputs just after the edge.
  task automatic applyStimulus(input logic xi, input logic ei, input logic ri);
    x     = xi;
    en    = ei;
    reset = ri;
    #6;
    sy0 = int'(y0);
    sy1 = int'(y1);
    @(posedge clk);
    #1;
    sp0 = int'(p0);
    sp1 = int'(p1);
    sc0 = int'(c0);
    sc1 = int'(c1);
  endtask

  logic [6:0] seq7   = 7'b1011011;
  logic [6:0] y0_029 = 7'b0001000;
  logic [6:0] y1_030 = 7'b0001001;
  logic [5:0] seq6   = 6'b101011;
  int         pre031 [5] = '{1, 2, 3, 2, 3};
  logic [3:0] seq4   = 4'b1011;
  int         sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    x = 1'b0; en = 1'b0; reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset_prefix0", sp0, 0);
    checkOutput("reset_prefix1", sp1, 0);
    checkOutput("reset_cnt0", sc0, 0);
    checkOutput("reset_cnt1", sc1, 0);

    // 1011011: non-overlap hits bit 4 only, overlap hits bits 4 and 7
    for (int i = 0; i < 7; i++) begin
      applyStimulus(seq7[6-i], 1'b1, 1'b0);
      checkOutput($sformatf("ovl0_y_bit%0d", i + 1), sy0, int'(y0_029[6-i]));
      checkOutput($sformatf("ovl1_y_bit%0d", i + 1), sy1, int'(y1_030[6-i]));
    end
    checkOutput("ovl0_cnt", sc0, CNT_ON ? 1 : 0);
    checkOutput("ovl1_cnt", sc1, CNT_ON ? 2 : 0);

    // Failure transitions with 101011
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(seq6[5-i], 1'b1, 1'b0);
      if (i < 5) checkOutput($sformatf("fail_prefix_bit%0d", i + 1), sp0, pre031[i]);
      checkOutput($sformatf("fail_y_bit%0d", i + 1), sy0, (i == 5) ? 1 : 0);
    end
    checkOutput("fail_prefix_after_ovl0", sp0, 0);
    checkOutput("fail_prefix_after_ovl1", sp1, 1);

    // Enable gating: two disabled cycles with random x between bits
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(seq4[3-i], 1'b1, 1'b0);
      checkOutput($sformatf("gate_y_bit%0d", i + 1), sy0, (i == 3) ? 1 : 0);
      checkOutput($sformatf("gate_y1_bit%0d", i + 1), sy1, (i == 3) ? 1 : 0);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
          checkOutput("gate_gap_y", sy0, 0);
          checkOutput("gate_gap_prefix", sp0, i + 1);
        end
      end
    end

    // Reset mid-pattern, with a match condition present during reset
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midrst_prefix_before", sp0, 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("midrst_y_in_reset0", sy0, 0);
    checkOutput("midrst_y_in_reset1", sy1, 0);
    checkOutput("midrst_prefix_after_reset", sp0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midrst_y_after", sy0, 0);
    checkOutput("midrst_prefix_final", sp0, 1);

    // Saturation of the 2-bit counter over five matches
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) applyStimulus(seq4[3-i], 1'b1, 1'b0);
      checkOutput($sformatf("sat_y_match%0d", m + 1), sy0, 1);
      checkOutput($sformatf("sat_cnt_match%0d", m + 1), sc0, CNT_ON ? sat_exp[m] : 0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..8.
REQ-002 SHALL have parameter PATTERN, default 4'b1011: target sequence, MSB received first.
REQ-003 SHALL have parameter OVERLAP, default 0: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: x is sampled only when en=1.
REQ-008 SHALL have port x, input, 1 bit: serial data bit.
REQ-009 SHALL have port y, output, 1 bit: Mealy match flag (found=1, notfound=0).
REQ-010 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-011 SHALL have port prefix_len, output, 4 bits: current state (matched prefix length, 0..PAT_W-1).

Function
REQ-012 SHALL be a Mealy FSM with states S0..S(PAT_W-1); state Sk means the last k sampled bits equal the first k bits of PATTERN.
REQ-013 SHALL assert y combinationally, in the same cycle, only when reset=0, en=1, state=S(PAT_W-1), and x equals the final pattern bit; y SHALL be 0 otherwise.
REQ-014 SHALL, when x extends the prefix (en=1, no match), go to S(k+1) on the next edge.
REQ-015 SHALL, on a mismatch, go to the longest proper suffix of (prefix + x) that is also a pattern prefix (KMP failure rule, elaboration-time computed).
REQ-016 SHALL, on a match with OVERLAP=1, go to the longest proper suffix of PATTERN that is also a prefix.
REQ-017 SHALL, on a match with OVERLAP=0, go to S0.
REQ-018 SHALL hold the state, y=0 and match_cnt when en=0, regardless of x.
REQ-019 SHALL increment match_cnt by 1 on the edge ending each y=1 cycle, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-020 SHALL drive prefix_len as the registered state index, zero-extended.
REQ-021 SHALL treat an unreachable state encoding as S0 on the next enabled edge.

Reset
REQ-022 SHALL, when reset=1 at a rising clk, set state to S0 and match_cnt to 0.
REQ-023 SHALL force y=0 while reset=1, even if a match condition holds.
REQ-024 SHALL give reset priority over en; a reset mid-pattern discards the partial prefix.

Configuration
REQ-025 SHALL, with macro PATTERN_DETECTOR_CNT_EN defined, include the saturating counter (REQ-019).
REQ-026 SHALL, without PATTERN_DETECTOR_CNT_EN, tie match_cnt to constant 0 and include no counter flops; y and the FSM SHALL be unchanged.

Structure
REQ-027 SHALL place the FOUND/NOTFOUND constants and the failure-function elaboration function in a shared package, pattern_pkg.
REQ-028 SHALL implement the counter as sub-module sat_counter (CNT_W parameter, inc, clk, reset); it is instantiated only under PATTERN_DETECTOR_CNT_EN.

Verification (PAT_W=4, PATTERN=1011, en=1 unless stated)
REQ-029 SHALL test OVERLAP=0 with x=1,0,1,1,0,1,1: y=1 only on bit 4; match_cnt=1.
REQ-030 SHALL test OVERLAP=1 with the same stimulus: y=1 on bits 4 and 7; match_cnt=2.
REQ-031 SHALL test failure transitions with x=1,0,1,0,1,1: prefix_len goes 1,2,3,2,3; y=1 on bit 6.
REQ-032 SHALL test en gating with 1,0,1,1 and en=0 cycles (x random) inserted between bits: y=0 in the gaps; y=1 on the final enabled bit.
REQ-033 SHALL test reset mid-pattern with 1,0,1, then reset one cycle, then x=1: prefix_len=1 and y=0 throughout.
REQ-034 SHALL test saturation with CNT_W=2 and five non-overlapping matches: match_cnt reads 1,2,3,3,3; without PATTERN_DETECTOR_CNT_EN, match_cnt=0 always.
